mult_ctrl: RTL and testbench
============================

# mult_ctrl

Iterative signed 32×32 multiplier controller. It sequences the existing shared 32-bit ALU through radix-2 Booth add/subtract steps to produce a 32-bit product plus an overflow exception. It sits beside the ALU in the processor datapath, drives the ALU operand and opcode inputs while busy, and reports completion with a one-cycle ready pulse.

## Interface
Parameters:
- ITER, 32: Booth iterations (one per multiplier bit).

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high.
- ctrl_MULT  in  1  start pulse; sampled only in IDLE.
- data_operandA  in  32  multiplicand (two's complement); captured at start.
- data_operandB  in  32  multiplier (two's complement); captured at start.
- alu_opcode  out  5  5'b00000 add, 5'b00001 subtract.
- alu_operandA  out  32  accumulator high word.
- alu_operandB  out  32  captured multiplicand.
- alu_result  in  32  combinational ALU sum/difference, same cycle.
- alu_overflow  in  1  combinational ALU signed overflow, same cycle.
- data_result  out  32  low 32 bits of product; registered.
- data_exception  out  1  product does not fit in 32 signed bits; registered.
- data_resultRDY  out  1  one-cycle completion pulse.
- busy  out  1  high in RUN; the ALU is owned by this block while high.

## Operation
- Registers: M[31:0] (multiplicand), HI[31:0], LO[31:0] (multiplier, then product low), Q (Booth bit q-1), CNT[5:0], state.
- States: IDLE, RUN, DONE.
- IDLE: if ctrl_MULT, load M←A, HI←0, LO←B, Q←0, CNT←0, go to RUN. Otherwise stay.
- RUN, per cycle, on {LO[0], Q}:
  - 01: alu_opcode = add. Sum S = alu_result; extension bit E = alu_result[31] ^ alu_overflow.
  - 10: alu_opcode = subtract; S and E as for 01.
  - 00 and 11: S = HI, E = HI[31]. alu_opcode is driven as add, and the result is ignored.
  - Then arithmetic shift right of {E, S, LO}: HI←{E, S[31:1]}, LO←{S[0], LO[31:1]}, Q←LO[0], CNT←CNT+1.
  - When CNT == ITER-1, go to DONE after this step.
- DONE (one cycle): data_result←LO. data_exception←1 unless all 32 bits of HI equal LO[31]. data_resultRDY=1. Go to IDLE.
- Outputs in IDLE and DONE: alu_operandA = HI and alu_operandB = M are still driven, but the ALU may be used by others.
- ctrl_MULT in RUN or DONE is ignored, not queued.
- The 33rd bit E handles the M = 0x80000000 subtract case without widening the ALU.

## Timing
- Reset values: state = IDLE, busy = 0, data_resultRDY = 0, data_result = 0, data_exception = 0, alu_opcode = 5'b00000, HI/LO/M/CNT/Q = 0.
- Latency: ctrl_MULT high in cycle t gives busy high in cycles t+1..t+32 and data_resultRDY high in cycle t+33 only.
- data_result and data_exception update at the edge ending cycle t+32, are valid with RDY, and hold until the next completion or reset.
- Back-to-back: the earliest next accepted start is ctrl_MULT in cycle t+34 (the IDLE cycle), i.e. a 34-cycle minimum period.
- Reset asserted mid-RUN or in DONE: at the next edge go to IDLE with all reset values. No RDY pulse is issued for the aborted operation.
- Simultaneous reset and ctrl_MULT: reset wins and the start is dropped.
- The ALU path is combinational from HI/M to alu_result; the whole step closes in one cycle.

## Structure
- Package mult_pkg holds:
  - ALU_ADD = 5'b00000, ALU_SUB = 5'b00001
  - state encoding IDLE/RUN/DONE (2 bits)
  - ITER default
- The ALU is not instantiated inside; it is shared at the top level, with a mux selected by busy.
- Sub-module mult_counter: 6-bit synchronous counter with clear, enable, and terminal-count flag at ITER-1.

## Test plan
- A=3, B=5, start → RDY at t+33, data_result=0x0000000F, exception=0; busy high exactly 32 cycles.
- A=-7 (0xFFFFFFF9), B=6 → 0xFFFFFFD6, exception=0. A=-1, B=-1 → 0x00000001, exception=0.
- A=0x80000000, B=1 → 0x80000000, exception=0. A=0x80000000, B=-1 → 0x80000000, exception=1.
- A=0x00010000, B=0x00010000 → 0x00000000, exception=1. A=0x7FFFFFFF, B=2 → 0xFFFFFFFE, exception=1.
- ctrl_MULT reasserted at t+5 and t+33 with different operands → ignored; exactly one RDY, first result unchanged. New start at t+34 → accepted.
- reset pulse at t+10 → busy=0 and all outputs at reset values next cycle, no RDY. Start at t+12 with 3×5 → 15 at t+45.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the iterative Booth multiplier.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mult_counter.sv
// Booth iteration counter: clear, count-enable, terminal flag at ITER-1.
// Latency: count updates on the edge after en_i; tc_o is a decode of the count register.
// Backpressure: none; clear has priority over enable.
module mult_counter #(
  parameter int ITER = 32
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [5:0] cnt_q;
  logic [5:0] cnt_d;

  // Next count: clear wins, otherwise step when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 6'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 6'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= 6'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == 6'(ITER - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Signed 32x32 Booth multiplier controller sequencing the shared external ALU.
// Latency: start in cycle t -> busy t+1..t+ITER, data_resultRDY pulse in t+ITER+1.
// Backpressure: none; ctrl_MULT outside IDLE is dropped, not queued.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [4:0]  alu_opcode,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        q_q, q_d;
  logic [31:0] res_q, res_d;
  logic        exc_q, exc_d;

  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;
  logic [31:0] step_s;
  logic        step_e;

  mult_counter #(
    .ITER (ITER)
  ) u_counter (
    .clock_i (clock),
    .reset_i (reset),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .tc_o    (cnt_tc)
  );

  // Next-state, Booth step datapath and ALU opcode selection.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    q_d        = q_q;
    res_d      = res_q;
    exc_d      = exc_q;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    alu_opcode = ALU_ADD;
    step_s     = hi_q;
    step_e     = hi_q[31];

    unique case (state_q)
      ST_IDLE: begin
        if (ctrl_MULT) begin
          m_d     = data_operandA;
          hi_d    = 32'd0;
          lo_d    = data_operandB;
          q_d     = 1'b0;
          cnt_clr = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // E is the true sign of the 33-bit sum, so M = 0x80000000 subtracts correctly.
        unique case ({lo_q[0], q_q})
          2'b01: begin
            alu_opcode = ALU_ADD;
            step_s     = alu_result;
            step_e     = alu_result[31] ^ alu_overflow;
          end
          2'b10: begin
            alu_opcode = ALU_SUB;
            step_s     = alu_result;
            step_e     = alu_result[31] ^ alu_overflow;
          end
          default: begin
            step_s = hi_q;
            step_e = hi_q[31];
          end
        endcase
        hi_d   = {step_e, step_s[31:1]};
        lo_d   = {step_s[0], lo_q[31:1]};
        q_d    = lo_q[0];
        cnt_en = 1'b1;
        if (cnt_tc) begin
          // Final step: latch the product so it is valid alongside the ready pulse.
          res_d   = lo_d;
          exc_d   = (hi_d != {32{lo_d[31]}});
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      m_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      q_q     <= 1'b0;
      res_q   <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      q_q     <= q_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign alu_operandA   = hi_q;
  assign alu_operandB   = m_q;
  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == ST_DONE);
  assign busy           = (state_q == ST_RUN);

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl with a behavioural ALU and product model.
// Latency: checks start->busy->ready timing on every directed operation.
// Backpressure: exercises ignored starts during RUN/DONE and reset aborts.
module tb_mult_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  mult_ctrl #(.ITER(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .alu_opcode     (alu_opcode),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Shared ALU: add or subtract with signed overflow.
  always_comb begin
    if (alu_opcode == 5'b00001) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) && (alu_result[31] != alu_operandA[31]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: full 64-bit signed product, overflow when it is not a 32-bit sign extension.
  task automatic ref_mult(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic e);
    longint sa, sb, p, lo_ext;
    logic [31:0] lo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = sa * sb;
    lo = p[31:0];
    lo_ext = longint'($signed(lo));
    r  = lo;
    e  = (p != lo_ext);
  endtask

  // Run one multiply from an IDLE negedge; verifies timing when full is set.
  task automatic do_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e, input bit full);
    int busy_cnt, rdy_cnt, rdy_at;
    logic [31:0] r_at;
    logic e_at;
    busy_cnt = 0; rdy_cnt = 0; rdy_at = 0; r_at = '0; e_at = 1'b0;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      @(negedge clock);
      if (k == 1) begin
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
      end
      if (busy) busy_cnt++;
      if (data_resultRDY) begin
        rdy_cnt++;
        if (rdy_at == 0) begin
          rdy_at = k;
          r_at   = data_result;
          e_at   = data_exception;
        end
      end
    end
    chk({tag, "_res"}, 64'(r_at), 64'(exp_r));
    chk({tag, "_exc"}, 64'(e_at), 64'(exp_e));
    if (full) begin
      chk({tag, "_rdy_at"}, 64'(rdy_at), 64'd33);
      chk({tag, "_rdy_cnt"}, 64'(rdy_cnt), 64'd1);
      chk({tag, "_busy_cnt"}, 64'(busy_cnt), 64'd32);
      chk({tag, "_hold"}, 64'(data_result), 64'(exp_r));
    end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [31:0] ra, rb, er;
    logic        ee;
    int          rdy_cnt;

    tbl[0] = '{32'd3,        32'd5,        32'h0000000F, 1'b0};
    tbl[1] = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 1'b0};
    tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    tbl[3] = '{32'h80000000, 32'd1,        32'h80000000, 1'b0};
    tbl[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    tbl[5] = '{32'h00010000, 32'h00010000, 32'h00000000, 1'b1};
    tbl[6] = '{32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1'b1};
    tbl[7] = '{32'h00000000, 32'h12345678, 32'h00000000, 1'b0};

    reset = 1'b1; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rdy", 64'(data_resultRDY), 64'd0);
    chk("rst_res", 64'(data_result), 64'd0);
    chk("rst_exc", 64'(data_exception), 64'd0);
    chk("rst_opc", 64'(alu_opcode), 64'd0);
    chk("rst_opa", 64'(alu_operandA), 64'd0);
    chk("rst_opb", 64'(alu_operandB), 64'd0);

    for (int i = 0; i < 8; i++) begin
      do_mult($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].exc, 1'b1);
    end

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'($signed(16'($urandom))); rb = 32'($signed(16'($urandom))); end
        2: begin ra = 32'h80000000; rb = $urandom; end
        default: begin ra = 32'($signed(8'($urandom))); rb = $urandom; end
      endcase
      ref_mult(ra, rb, er, ee);
      do_mult($sformatf("rnd%0d", i), ra, rb, er, ee, (i % 5) == 0);
    end

    // Starts during RUN and DONE are dropped; the IDLE start right after is accepted.
    data_operandA = 32'd3; data_operandB = 32'd5; ctrl_MULT = 1'b1;
    rdy_cnt = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      if (data_resultRDY) rdy_cnt++;
      if (c == 33) begin
        chk("b2b_rdy1", 64'(data_resultRDY), 64'd1);
        chk("b2b_res1", 64'(data_result), 64'd15);
      end
      if (c == 34) chk("b2b_hold", 64'(data_result), 64'd15);
      if (c == 35) chk("b2b_busy2", 64'(busy), 64'd1);
      if (c == 50) chk("b2b_keep", 64'(data_result), 64'd15);
      if (c == 67) begin
        chk("b2b_rdy2", 64'(data_resultRDY), 64'd1);
        chk("b2b_res2", 64'(data_result), 64'd63);
      end
      if (c == 5)  begin data_operandA = 32'd100; data_operandB = 32'd100; ctrl_MULT = 1'b1; end
      if (c == 33) begin data_operandA = 32'd11;  data_operandB = 32'd13;  ctrl_MULT = 1'b1; end
      if (c == 34) begin data_operandA = 32'd7;   data_operandB = 32'd9;   ctrl_MULT = 1'b1; end
    end
    chk("b2b_rdy_cnt", 64'(rdy_cnt), 64'd2);

    // Reset mid-RUN aborts silently; a fresh start afterwards completes normally.
    data_operandA = 32'd9; data_operandB = 32'd9; ctrl_MULT = 1'b1;
    rdy_cnt = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clock);
      ctrl_MULT = 1'b0;
      if (c == 11) reset = 1'b0;
      if (data_resultRDY) rdy_cnt++;
      if (c == 11) begin
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rdy", 64'(data_resultRDY), 64'd0);
        chk("abort_res", 64'(data_result), 64'd0);
        chk("abort_exc", 64'(data_exception), 64'd0);
        chk("abort_opc", 64'(alu_opcode), 64'd0);
        chk("abort_opa", 64'(alu_operandA), 64'd0);
        chk("abort_opb", 64'(alu_operandB), 64'd0);
      end
      if (c == 45) begin
        chk("abort_rdy45", 64'(data_resultRDY), 64'd1);
        chk("abort_res45", 64'(data_result), 64'd15);
      end
      if (c == 10) reset = 1'b1;
      if (c == 12) begin data_operandA = 32'd3; data_operandB = 32'd5; ctrl_MULT = 1'b1; end
    end
    chk("abort_rdy_cnt", 64'(rdy_cnt), 64'd1);

    // Reset and start together: reset wins.
    reset = 1'b1; ctrl_MULT = 1'b1; data_operandA = 32'd3; data_operandB = 32'd5;
    @(negedge clock);
    reset = 1'b0; ctrl_MULT = 1'b0;
    @(negedge clock);
    chk("rst_start_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
